mem_ctrl: RTL and testbench

//   Byte-serial memory controller between the load/store buffer, instruction fetch and the 8-bit RAM/IO bus.

---
 rtl/mem_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Byte-serial memory controller. It sits between the load/store buffer (LSB),
//   instruction fetch and an 8-bit RAM/IO bus. It arbitrates the two requesters,
//   giving the LSB priority. It splits every access into little-endian byte
//   cycles, assembles and extends load data, and returns completion pulses.
//
// Ports
//   clk_in, rst_in, rdy_in  clock, synchronous active-high reset, global ready
//   clear                   mispredict flush (only acts while rdy_in is high)
//   io_buffer_full          stalls stores to IO space (addr >= IO_BASE)
//   ls_enable/addr/store_val/lsb_type -> ls_finished/load_val   LSB side
//   if_enable/if_addr                 -> if_finished/if_data    fetch side
//   mem_din/mem_dout/mem_a/mem_wr     byte bus (RAM read latency 1 cycle)
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic        ls_enable,
    input  logic [31:0] addr,
    input  logic [31:0] store_val,
    input  logic [3:0]  lsb_type,
    output logic        ls_finished,
    output logic [31:0] load_val,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_finished,
    output logic [31:0] if_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;            // byte index k of the current access
    logic [23:0] bytes, bytes_next;        // bytes 0..2 already read
    logic        suppress, suppress_next;  // store flushed: finish silently
    logic [31:0] base, base_next;
    logic [2:0]  ltype, ltype_next;        // {unsigned, size[1:0]}
    logic [31:0] sdata, sdata_next;

    logic [2:0]  len;
    logic [31:0] raw;
    logic        live;
    logic        stall;

    function automatic logic [2:0] access_len(input logic [1:0] size);
        case (size)
            2'd0:    access_len = 3'd1;
            2'd1:    access_len = 3'd2;
            default: access_len = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] r, input logic [2:0] t);
        case (t[1:0])
            2'd0:    extend_load = t[2] ? {24'd0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
            2'd1:    extend_load = t[2] ? {16'd0, r[15:0]} : {{16{r[15]}}, r[15:0]};
            default: extend_load = r;
        endcase
    endfunction

    assign live  = rdy_in && !rst_in;
    assign len   = (state == FETCH) ? 3'd4 : access_len(ltype[1:0]);
    assign stall = (base >= IO_BASE) && io_buffer_full;

    // The last byte is taken straight from the bus, earlier ones from the buffer.
    always_comb begin
        case (len)
            3'd1:    raw = {24'd0, mem_din};
            3'd2:    raw = {16'd0, mem_din, bytes[7:0]};
            default: raw = {mem_din, bytes};
        endcase
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        bytes_next    = bytes;
        suppress_next = suppress;
        base_next     = base;
        ltype_next    = ltype;
        sdata_next    = sdata;
        mem_a         = 32'd0;
        mem_dout      = 8'd0;
        mem_wr        = 1'b0;
        ls_finished   = 1'b0;
        load_val      = 32'd0;
        if_finished   = 1'b0;
        if_data       = 32'd0;

        case (state)
            IDLE: begin
                if (rdy_in && !clear) begin
                    if (ls_enable) begin
                        state_next    = lsb_type[3] ? STORE : LOAD;
                        base_next     = addr;
                        ltype_next    = lsb_type[2:0];
                        sdata_next    = store_val;
                        cnt_next      = 3'd0;
                        suppress_next = 1'b0;
                    end else if (if_enable) begin
                        state_next    = FETCH;
                        base_next     = if_addr;
                        ltype_next    = 3'b010;
                        cnt_next      = 3'd0;
                        suppress_next = 1'b0;
                    end
                end
            end

            LOAD, FETCH: begin
                // While frozen, keep presenting the previous address so the RAM
                // keeps returning the byte that is due when rdy_in comes back.
                if (!rdy_in)
                    mem_a = base + {29'd0, cnt} - 32'd1;
                else if (cnt < len)
                    mem_a = base + {29'd0, cnt};

                if (rdy_in) begin
                    if (clear) begin
                        state_next = IDLE;
                        cnt_next   = 3'd0;
                    end else if (cnt == len) begin
                        state_next = IDLE;
                        cnt_next   = 3'd0;
                        if (live) begin
                            if (state == LOAD) begin
                                ls_finished = 1'b1;
                                load_val    = extend_load(raw, ltype);
                            end else begin
                                if_finished = 1'b1;
                                if_data     = raw;
                            end
                        end
                    end else begin
                        case (cnt)
                            3'd1:    bytes_next[7:0]   = mem_din;
                            3'd2:    bytes_next[15:8]  = mem_din;
                            3'd3:    bytes_next[23:16] = mem_din;
                            default: ;
                        endcase
                        cnt_next = cnt + 3'd1;
                    end
                end
            end

            STORE: begin
                mem_a = base + {29'd0, cnt};
                case (cnt[1:0])
                    2'd0: mem_dout = sdata[7:0];
                    2'd1: mem_dout = sdata[15:8];
                    2'd2: mem_dout = sdata[23:16];
                    2'd3: mem_dout = sdata[31:24];
                endcase
                // A flushed store still writes its remaining bytes.
                if (rdy_in && clear)
                    suppress_next = 1'b1;
                if (live && !stall) begin
                    mem_wr = 1'b1;
                    if (cnt == len - 3'd1) begin
                        ls_finished = !suppress && !clear;
                        state_next  = IDLE;
                        cnt_next    = 3'd0;
                    end else begin
                        cnt_next = cnt + 3'd1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            bytes    <= 24'd0;
            suppress <= 1'b0;
        end else if (rdy_in) begin
            state    <= state_next;
            cnt      <= cnt_next;
            bytes    <= bytes_next;
            suppress <= suppress_next;
        end
    end

    // Access descriptor; only meaningful outside IDLE, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            base  <= base_next;
            ltype <= ltype_next;
            sdata <= sdata_next;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, io_buffer_full;
    logic        ls_enable, if_enable;
    logic [31:0] addr, store_val, if_addr;
    logic [3:0]  lsb_type;
    logic        ls_finished, if_finished, mem_wr;
    logic [31:0] load_val, if_data, mem_a;
    logic [7:0]  mem_din, mem_dout;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .io_buffer_full(io_buffer_full), .ls_enable(ls_enable), .addr(addr),
        .store_val(store_val), .lsb_type(lsb_type), .ls_finished(ls_finished),
        .load_val(load_val), .if_enable(if_enable), .if_addr(if_addr),
        .if_finished(if_finished), .if_data(if_data), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: 1-cycle read latency, write log, preloaded during reset.
    logic [7:0]  ram [0:65535];
    logic [31:0] wr_a [0:255];
    logic [7:0]  wr_d [0:255];
    int          nwr = 0;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        if (rst_in) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
            ram[16'h1000] <= 8'h78; ram[16'h1001] <= 8'h56;
            ram[16'h1002] <= 8'h34; ram[16'h1003] <= 8'h12;
            ram[16'h0020] <= 8'h80;
            ram[16'h1010] <= 8'h9A; ram[16'h1011] <= 8'hBC;
            ram[16'h1012] <= 8'hDE; ram[16'h1013] <= 8'h01;
        end else if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
            wr_a[nwr % 256]  <= mem_a;
            wr_d[nwr % 256]  <= mem_dout;
            nwr              <= nwr + 1;
        end
    end

    int nvec = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One request; lat = cycles from accept cycle A to the finished pulse (-1 on timeout).
    task automatic do_req(input bit fetch, input logic [31:0] a, input logic [31:0] sv,
                          input logic [3:0] t, output logic [31:0] got, output int lat);
        @(posedge clk_in); #1;
        if (fetch) begin
            if_enable = 1'b1; if_addr = a;
        end else begin
            ls_enable = 1'b1; addr = a; store_val = sv; lsb_type = t;
        end
        got = '0;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (fetch ? if_finished : ls_finished) begin
                got = fetch ? if_data : load_val;
                lat = c;
                break;
            end
            @(posedge clk_in); #1;
        end
        @(posedge clk_in); #1;
        ls_enable = 1'b0;
        if_enable = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] sv;
        logic [3:0]  t;
        logic [31:0] exp;
        int          lat;
        int          nw;
    } vec_t;

    vec_t        vt [14];
    logic [31:0] got, lsv, ifd;
    int          lat, n0, ls_c, if_c;
    logic        seen;

    initial begin
        vt[0]  = '{32'h1000, 32'h0,        4'h2, 32'h12345678, 5, 0};
        vt[1]  = '{32'h0020, 32'h0,        4'h0, 32'hFFFFFF80, 2, 0};
        vt[2]  = '{32'h0020, 32'h0,        4'h4, 32'h00000080, 2, 0};
        vt[3]  = '{32'h1000, 32'h0,        4'h1, 32'h00005678, 3, 0};
        vt[4]  = '{32'h1002, 32'h0,        4'h1, 32'h00001234, 3, 0};
        vt[5]  = '{32'h1010, 32'h0,        4'h1, 32'hFFFFBC9A, 3, 0};
        vt[6]  = '{32'h1010, 32'h0,        4'h5, 32'h0000BC9A, 3, 0};
        vt[7]  = '{32'h3000, 32'hCAFEBABE, 4'hA, 32'h0,        4, 4};
        vt[8]  = '{32'h3000, 32'h0,        4'h2, 32'hCAFEBABE, 5, 0};
        vt[9]  = '{32'h3005, 32'h11223377, 4'h8, 32'h0,        1, 1};
        vt[10] = '{32'h3004, 32'h0,        4'h2, 32'h00007700, 5, 0};
        vt[11] = '{32'h2002, 32'h0000BEEF, 4'h9, 32'h0,        2, 2};
        vt[12] = '{32'h2000, 32'h0,        4'h2, 32'hBEEF0000, 5, 0};
        vt[13] = '{32'h3003, 32'h0,        4'h0, 32'hFFFFFFCA, 2, 0};

        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        ls_enable = 1'b0; if_enable = 1'b0; addr = '0; store_val = '0;
        if_addr = '0; lsb_type = '0;

        // Reset state
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_ls_fin", {31'd0, ls_finished}, 32'd0);
        check("rst_if_fin", {31'd0, if_finished}, 32'd0);
        check("rst_load_val", load_val, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        @(posedge clk_in); #1 rst_in = 1'b0;

        // Table of single LSB accesses
        for (int i = 0; i < 14; i++) begin
            n0 = nwr;
            do_req(1'b0, vt[i].a, vt[i].sv, vt[i].t, got, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            if (!vt[i].t[3]) check($sformatf("v%0d_load_val", i), got, vt[i].exp);
            check($sformatf("v%0d_writes", i), 32'(nwr - n0), 32'(vt[i].nw));
        end

        // SH byte order and addresses
        n0 = nwr;
        do_req(1'b0, 32'h2002, 32'h0000BEEF, 4'h9, got, lat);
        check("sh_addr0", wr_a[n0 % 256], 32'h2002);
        check("sh_data0", {24'd0, wr_d[n0 % 256]}, 32'hEF);
        check("sh_addr1", wr_a[(n0 + 1) % 256], 32'h2003);
        check("sh_data1", {24'd0, wr_d[(n0 + 1) % 256]}, 32'hBE);

        // Simultaneous requests: LSB first, fetch right after
        @(posedge clk_in); #1;
        ls_enable = 1'b1; addr = 32'h1000; lsb_type = 4'h2;
        if_enable = 1'b1; if_addr = 32'h1010;
        ls_c = -1; if_c = -1; lsv = '0; ifd = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            if (ls_finished) begin ls_c = c; lsv = load_val; end
            if (if_finished) begin if_c = c; ifd = if_data; end
            @(posedge clk_in); #1;
            if (ls_c == c) ls_enable = 1'b0;
            if (if_c == c) begin if_enable = 1'b0; break; end
        end
        ls_enable = 1'b0; if_enable = 1'b0;
        check("arb_ls_cycle", 32'(ls_c), 32'd5);
        check("arb_ls_val", lsv, 32'h12345678);
        check("arb_if_cycle", 32'(if_c), 32'd11);
        check("arb_if_data", ifd, 32'h01DEBC9A);

        // IO store stalled by a full UART buffer
        @(posedge clk_in); #1;
        ls_enable = 1'b1; addr = 32'h0003_0000; store_val = 32'h41; lsb_type = 4'h8;
        io_buffer_full = 1'b1;
        n0 = nwr;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk_in); #1;
            @(negedge clk_in);
            check($sformatf("io_stall_wr%0d", i), {31'd0, mem_wr}, 32'd0);
        end
        @(posedge clk_in); #1 io_buffer_full = 1'b0;
        @(negedge clk_in);
        check("io_wr", {31'd0, mem_wr}, 32'd1);
        check("io_dout", {24'd0, mem_dout}, 32'h41);
        check("io_addr", mem_a, 32'h0003_0000);
        check("io_fin", {31'd0, ls_finished}, 32'd1);
        @(posedge clk_in); #1 ls_enable = 1'b0;
        check("io_writes", 32'(nwr - n0), 32'd1);

        // clear at A+2 of a fetch
        @(posedge clk_in); #1 if_enable = 1'b1; if_addr = 32'h1000;
        seen = 1'b0;
        @(negedge clk_in); seen = seen | if_finished;
        @(posedge clk_in); #1;
        @(negedge clk_in); seen = seen | if_finished;
        @(posedge clk_in); #1 clear = 1'b1; if_enable = 1'b0;
        @(negedge clk_in); seen = seen | if_finished;
        @(posedge clk_in); #1 clear = 1'b0;
        @(negedge clk_in); seen = seen | if_finished;
        check("clear_idle_mem_a", mem_a, 32'd0);
        repeat (4) begin
            @(posedge clk_in); #1;
            @(negedge clk_in); seen = seen | if_finished;
        end
        check("clear_no_finish", {31'd0, seen}, 32'd0);
        do_req(1'b1, 32'h1010, 32'h0, 4'h0, got, lat);
        check("fetch_after_clear_lat", 32'(lat), 32'd5);
        check("fetch_after_clear_data", got, 32'h01DEBC9A);

        // rdy_in low for 2 cycles mid-LW
        @(posedge clk_in); #1 ls_enable = 1'b1; addr = 32'h1000; lsb_type = 4'h2;
        ls_c = -1; lsv = '0;
        for (int c = 0; c < 20; c++) begin
            rdy_in = !(c == 2 || c == 3);
            @(negedge clk_in);
            if (ls_finished) begin ls_c = c; lsv = load_val; break; end
            @(posedge clk_in); #1;
        end
        @(posedge clk_in); #1 ls_enable = 1'b0; rdy_in = 1'b1;
        check("freeze_cycle", 32'(ls_c), 32'd7);
        check("freeze_val", lsv, 32'h12345678);

        // Reset in the middle of a word store
        @(posedge clk_in); #1;
        ls_enable = 1'b1; addr = 32'h3100; store_val = 32'hAABBCCDD; lsb_type = 4'hA;
        n0 = nwr;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(negedge clk_in);
        check("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk_in); #1 rst_in = 1'b0; ls_enable = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        check("rst_mid_writes", 32'(nwr - n0), 32'd1);
        check("rst_mid_idle", mem_a, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
